// File: rtl/mem_bus_arbiter_if.sv
// Cache/memory bus bundle for the shared line-transfer arbiter.
// master: the arbiter's view. slave: the surrounding caches and memory.
interface mem_bus_arbiter_if #(
  parameter int unsigned ADDR_W = 64
);
  localparam int unsigned DATA_W = 64;

  // I-cache side
  logic              ic_req_i;
  logic [ADDR_W-1:0] ic_addr_i;
  logic              ic_gnt_o;
  logic              ic_rvalid_o;
  logic [DATA_W-1:0] ic_rdata_o;
  logic              ic_rlast_o;

  // D-cache side
  logic              dc_req_i;
  logic              dc_wr_i;
  logic [ADDR_W-1:0] dc_addr_i;
  logic              dc_gnt_o;
  logic              dc_wvalid_i;
  logic [DATA_W-1:0] dc_wdata_i;
  logic              dc_wready_o;
  logic              dc_rvalid_o;
  logic [DATA_W-1:0] dc_rdata_o;
  logic              dc_rlast_o;
  logic              dc_bdone_o;

  // Memory side
  logic              mem_req_o;
  logic              mem_wr_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_ack_i;
  logic              mem_wvalid_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              mem_wlast_o;
  logic              mem_wready_i;
  logic              mem_rvalid_i;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              mem_bvalid_i;

  modport master (
    input  ic_req_i, ic_addr_i,
    output ic_gnt_o, ic_rvalid_o, ic_rdata_o, ic_rlast_o,
    input  dc_req_i, dc_wr_i, dc_addr_i, dc_wvalid_i, dc_wdata_i,
    output dc_gnt_o, dc_wready_o, dc_rvalid_o, dc_rdata_o, dc_rlast_o, dc_bdone_o,
    output mem_req_o, mem_wr_o, mem_addr_o, mem_wvalid_o, mem_wdata_o, mem_wlast_o,
    input  mem_ack_i, mem_wready_i, mem_rvalid_i, mem_rdata_i, mem_bvalid_i
  );

  modport slave (
    output ic_req_i, ic_addr_i,
    input  ic_gnt_o, ic_rvalid_o, ic_rdata_o, ic_rlast_o,
    output dc_req_i, dc_wr_i, dc_addr_i, dc_wvalid_i, dc_wdata_i,
    input  dc_gnt_o, dc_wready_o, dc_rvalid_o, dc_rdata_o, dc_rlast_o, dc_bdone_o,
    input  mem_req_o, mem_wr_o, mem_addr_o, mem_wvalid_o, mem_wdata_o, mem_wlast_o,
    output mem_ack_i, mem_wready_i, mem_rvalid_i, mem_rdata_i, mem_bvalid_i
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory port between I-cache fills and
// D-cache fills/writebacks; one cache-line transaction at a time.
module mem_bus_arbiter #(
  parameter int unsigned BEATS  = 4,
  parameter int unsigned ADDR_W = 64
) (
  input logic               clk,
  input logic               reset,
  mem_bus_arbiter_if.master bus
);

  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  localparam logic [2:0] S_ARB_IDLE  = 3'd0;
  localparam logic [2:0] S_ARB_ADDR  = 3'd1;
  localparam logic [2:0] S_ARB_RDATA = 3'd2;
  localparam logic [2:0] S_ARB_WDATA = 3'd3;
  localparam logic [2:0] S_ARB_WRESP = 3'd4;

  logic [2:0]        r_state;
  logic [2:0]        w_state_nxt;
  logic              r_owner;    // 0 = I-cache, 1 = D-cache
  logic              r_wr;
  logic [ADDR_W-1:0] r_addr;
  logic              r_rr_last;  // set after an I grant so D wins the next tie
  logic [CNT_W-1:0]  r_cnt;
  logic              r_ic_gnt;
  logic              r_dc_gnt;
  logic              r_bdone;

  logic w_take_ic;
  logic w_take_dc;
  logic w_rbeat;
  logic w_wbeat;
  logic w_bdone;
  logic w_last;
  logic w_ic_rv;
  logic w_dc_rv;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_ARB_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state decode and combinational bus steering
  always_comb begin
    w_state_nxt = r_state;
    w_take_ic   = 1'b0;
    w_take_dc   = 1'b0;
    w_rbeat     = 1'b0;
    w_wbeat     = 1'b0;
    w_bdone     = 1'b0;
    w_last      = (r_cnt == LAST_BEAT);

    case (r_state)
      S_ARB_IDLE: begin
        if (bus.ic_req_i && (!bus.dc_req_i || !r_rr_last)) begin
          w_take_ic   = 1'b1;
          w_state_nxt = S_ARB_ADDR;
        end else if (bus.dc_req_i) begin
          w_take_dc   = 1'b1;
          w_state_nxt = S_ARB_ADDR;
        end
      end
      S_ARB_ADDR: begin
        if (bus.mem_ack_i) w_state_nxt = r_wr ? S_ARB_WDATA : S_ARB_RDATA;
      end
      S_ARB_RDATA: begin
        w_rbeat = bus.mem_rvalid_i;
        if (w_rbeat && w_last) w_state_nxt = S_ARB_IDLE;
      end
      S_ARB_WDATA: begin
        w_wbeat = bus.dc_wvalid_i && bus.mem_wready_i;
        if (w_wbeat && w_last) w_state_nxt = S_ARB_WRESP;
      end
      S_ARB_WRESP: begin
        w_bdone = bus.mem_bvalid_i;
        if (w_bdone) w_state_nxt = S_ARB_IDLE;
      end
      default: w_state_nxt = S_ARB_IDLE;
    endcase

    w_ic_rv = w_rbeat && !r_owner;
    w_dc_rv = w_rbeat && r_owner;

    bus.mem_req_o    = (r_state == S_ARB_ADDR);
    bus.mem_wr_o     = (r_state == S_ARB_ADDR) && r_wr;
    bus.mem_addr_o   = r_addr;

    bus.ic_rvalid_o  = w_ic_rv;
    bus.ic_rdata_o   = w_ic_rv ? bus.mem_rdata_i : '0;
    bus.ic_rlast_o   = w_ic_rv && w_last;
    bus.dc_rvalid_o  = w_dc_rv;
    bus.dc_rdata_o   = w_dc_rv ? bus.mem_rdata_i : '0;
    bus.dc_rlast_o   = w_dc_rv && w_last;

    bus.mem_wvalid_o = (r_state == S_ARB_WDATA) && bus.dc_wvalid_i;
    bus.mem_wdata_o  = (r_state == S_ARB_WDATA) ? bus.dc_wdata_i : '0;
    bus.mem_wlast_o  = bus.mem_wvalid_o && w_last;
    bus.dc_wready_o  = (r_state == S_ARB_WDATA) && bus.mem_wready_i;

    bus.ic_gnt_o     = r_ic_gnt;
    bus.dc_gnt_o     = r_dc_gnt;
    bus.dc_bdone_o   = r_bdone;
  end

  // Owner/address latch, round-robin pointer, beat counter, grant/done pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_owner   <= 1'b0;
      r_wr      <= 1'b0;
      r_addr    <= '0;
      r_rr_last <= 1'b0;
      r_cnt     <= '0;
      r_ic_gnt  <= 1'b0;
      r_dc_gnt  <= 1'b0;
      r_bdone   <= 1'b0;
    end else begin
      r_ic_gnt <= w_take_ic;
      r_dc_gnt <= w_take_dc;
      r_bdone  <= w_bdone;
      if (w_take_ic) begin
        r_owner   <= 1'b0;
        r_wr      <= 1'b0;
        r_addr    <= bus.ic_addr_i;
        r_rr_last <= 1'b1;
      end else if (w_take_dc) begin
        r_owner   <= 1'b1;
        r_wr      <= bus.dc_wr_i;
        r_addr    <= bus.dc_addr_i;
        r_rr_last <= 1'b0;
      end
      if ((r_state == S_ARB_ADDR) && bus.mem_ack_i) r_cnt <= '0;
      else if (w_rbeat || w_wbeat)                  r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed scoreboard bench for mem_bus_arbiter.
module tb_mem_bus_arbiter;

  localparam int BEATS  = 4;
  localparam int ADDR_W = 64;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  mem_bus_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  mem_bus_arbiter #(.BEATS(BEATS), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_pass   = 0;
  int n_fail   = 0;
  int n_total  = 0;
  int n_ic_gnt = 0;
  int n_dc_gnt = 0;
  int n_bdone  = 0;

  logic [64:0] q_ic[$];
  logic [64:0] q_dc[$];
  logic [64:0] q_wr[$];

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Output monitor: counts pulses and pops the scoreboard on every beat
  always @(negedge clk) begin
    if (bus.ic_gnt_o)   n_ic_gnt++;
    if (bus.dc_gnt_o)   n_dc_gnt++;
    if (bus.dc_bdone_o) n_bdone++;
    if (bus.ic_rvalid_o) begin
      if (q_ic.size() == 0) chk("ic_rvalid_unexpected", 65'(bus.ic_rvalid_o), 65'(0));
      else                  chk("ic_rbeat", {bus.ic_rlast_o, bus.ic_rdata_o}, q_ic.pop_front());
    end
    if (bus.dc_rvalid_o) begin
      if (q_dc.size() == 0) chk("dc_rvalid_unexpected", 65'(bus.dc_rvalid_o), 65'(0));
      else                  chk("dc_rbeat", {bus.dc_rlast_o, bus.dc_rdata_o}, q_dc.pop_front());
    end
    if (bus.mem_wvalid_o && bus.mem_wready_i) begin
      if (q_wr.size() == 0) chk("wbeat_unexpected", 65'(bus.mem_wvalid_o), 65'(0));
      else                  chk("wbeat", {bus.mem_wlast_o, bus.mem_wdata_o}, q_wr.pop_front());
    end
  end

  task automatic clear_inputs();
    bus.ic_req_i     = 1'b0;
    bus.ic_addr_i    = '0;
    bus.dc_req_i     = 1'b0;
    bus.dc_wr_i      = 1'b0;
    bus.dc_addr_i    = '0;
    bus.dc_wvalid_i  = 1'b0;
    bus.dc_wdata_i   = '0;
    bus.mem_ack_i    = 1'b0;
    bus.mem_wready_i = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = '0;
    bus.mem_bvalid_i = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    clear_inputs();
    q_ic.delete();
    q_dc.delete();
    q_wr.delete();
    repeat (2) tick();
    @(negedge clk);
    chk("rst_mem_req",  65'(bus.mem_req_o),   65'(0));
    chk("rst_mem_addr", 65'(bus.mem_addr_o),  65'(0));
    chk("rst_ic_gnt",   65'(bus.ic_gnt_o),    65'(0));
    chk("rst_dc_gnt",   65'(bus.dc_gnt_o),    65'(0));
    chk("rst_bdone",    65'(bus.dc_bdone_o),  65'(0));
    chk("rst_wvalid",   65'(bus.mem_wvalid_o), 65'(0));
    tick();
    reset = 1'b0;
  endtask

  task automatic req_on(input bit is_d, input bit wr, input logic [63:0] addr);
    if (is_d) begin
      bus.dc_req_i  = 1'b1;
      bus.dc_wr_i   = wr;
      bus.dc_addr_i = addr;
    end else begin
      bus.ic_req_i  = 1'b1;
      bus.ic_addr_i = addr;
    end
  endtask

  // Wait for the grant, run address phase and data phases, push expected beats
  task automatic serve(input bit is_d, input bit wr, input logic [63:0] addr,
                       input logic [63:0] base, input int ack_delay,
                       input int abort_at, input bit stray_b);
    int g0;
    int b0;
    int bidx;
    int cyc;
    bit got;
    g0  = n_ic_gnt + n_dc_gnt;
    b0  = n_bdone;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.ic_gnt_o || bus.dc_gnt_o) begin
        got = 1'b1;
        break;
      end
    end
    chk("gnt_seen",  65'(got),            65'(1));
    chk("ic_gnt",    65'(bus.ic_gnt_o),   65'(!is_d));
    chk("dc_gnt",    65'(bus.dc_gnt_o),   65'(is_d));
    chk("mem_req",   65'(bus.mem_req_o),  65'(1));
    chk("mem_addr",  65'(bus.mem_addr_o), 65'(addr));
    chk("mem_wr",    65'(bus.mem_wr_o),   65'(wr));
    tick();
    if (is_d) bus.dc_req_i = 1'b0;
    else      bus.ic_req_i = 1'b0;
    for (int i = 0; i < ack_delay; i++) begin
      @(negedge clk);
      chk("hold_req",  65'(bus.mem_req_o),  65'(1));
      chk("hold_addr", 65'(bus.mem_addr_o), 65'(addr));
      tick();
    end
    bus.mem_ack_i = 1'b1;
    tick();
    bus.mem_ack_i = 1'b0;
    if (!wr) begin
      for (int b = 0; b < BEATS; b++) begin
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = base + 64'(b);
        bus.mem_bvalid_i = stray_b && (b == 1);
        if (b == abort_at) begin
          reset = 1'b1;
          @(negedge clk);
          chk("abort_ic_rvalid", 65'(bus.ic_rvalid_o), 65'(0));
          chk("abort_ic_rlast",  65'(bus.ic_rlast_o),  65'(0));
          chk("abort_dc_rvalid", 65'(bus.dc_rvalid_o), 65'(0));
          chk("abort_mem_req",   65'(bus.mem_req_o),   65'(0));
          chk("abort_mem_addr",  65'(bus.mem_addr_o),  65'(0));
          tick();
          reset = 1'b0;
          clear_inputs();
          return;
        end
        if (is_d) q_dc.push_back({b == BEATS - 1, base + 64'(b)});
        else      q_ic.push_back({b == BEATS - 1, base + 64'(b)});
        tick();
      end
      bus.mem_rvalid_i = 1'b0;
      bus.mem_rdata_i  = '0;
      bus.mem_bvalid_i = 1'b0;
      @(negedge clk);
      chk("rd_drain",  65'(q_ic.size() + q_dc.size()), 65'(0));
      chk("no_bdone",  65'(n_bdone - b0),              65'(0));
      tick();
    end else begin
      bidx = 0;
      cyc  = 0;
      while (bidx < BEATS && cyc < 40) begin
        bus.dc_wvalid_i  = 1'b1;
        bus.dc_wdata_i   = base + 64'(bidx);
        bus.mem_wready_i = !(cyc == 1 || cyc == 2);
        if (bus.mem_wready_i) q_wr.push_back({bidx == BEATS - 1, base + 64'(bidx)});
        @(negedge clk);
        chk("dc_wready", 65'(bus.dc_wready_o), 65'(bus.mem_wready_i));
        chk("wlast",     65'(bus.mem_wlast_o), 65'(bidx == BEATS - 1));
        tick();
        if (bus.mem_wready_i) bidx++;
        cyc++;
      end
      bus.dc_wvalid_i  = 1'b0;
      bus.mem_wready_i = 1'b0;
      chk("wr_drain", 65'(q_wr.size()), 65'(0));
      tick();
      bus.mem_bvalid_i = 1'b1;
      @(negedge clk);
      chk("bdone_pre",   65'(bus.dc_bdone_o), 65'(0));
      tick();
      bus.mem_bvalid_i = 1'b0;
      @(negedge clk);
      chk("bdone_pulse", 65'(bus.dc_bdone_o), 65'(1));
      tick();
      @(negedge clk);
      chk("bdone_clear", 65'(bus.dc_bdone_o), 65'(0));
      chk("bdone_count", 65'(n_bdone - b0),   65'(1));
      tick();
    end
    chk("gnt_once", 65'(n_ic_gnt + n_dc_gnt - g0), 65'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    clear_inputs();
    apply_reset();

    // Single I-cache fill, ack on the next cycle
    req_on(1'b0, 1'b0, 64'h1000);
    serve(1'b0, 1'b0, 64'h1000, 64'hA000, 0, -1, 1'b0);
    chk("t1_no_dc_gnt", 65'(n_dc_gnt), 65'(0));

    // Stray memory responses while idle
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 64'hDEAD;
    bus.mem_bvalid_i = 1'b1;
    bus.mem_wready_i = 1'b1;
    @(negedge clk);
    chk("idle_ic_rvalid", 65'(bus.ic_rvalid_o), 65'(0));
    chk("idle_dc_rvalid", 65'(bus.dc_rvalid_o), 65'(0));
    chk("idle_wready",    65'(bus.dc_wready_o), 65'(0));
    tick();
    @(negedge clk);
    chk("idle_bdone",     65'(bus.dc_bdone_o),  65'(0));
    chk("idle_mem_req",   65'(bus.mem_req_o),   65'(0));
    tick();
    clear_inputs();

    // Contention from reset: I, then D, then I again on the next tie
    apply_reset();
    req_on(1'b0, 1'b0, 64'h3000);
    req_on(1'b1, 1'b0, 64'h4000);
    serve(1'b0, 1'b0, 64'h3000, 64'hB000, 0, -1, 1'b0);
    serve(1'b1, 1'b0, 64'h4000, 64'hC000, 0, -1, 1'b0);
    req_on(1'b0, 1'b0, 64'h3040);
    req_on(1'b1, 1'b0, 64'h4040);
    serve(1'b0, 1'b0, 64'h3040, 64'hB100, 0, -1, 1'b0);
    serve(1'b1, 1'b0, 64'h4040, 64'hC100, 0, -1, 1'b0);

    // D-cache writeback with a two-cycle wready stall
    req_on(1'b1, 1'b1, 64'h2040);
    serve(1'b1, 1'b1, 64'h2040, 64'hD000, 0, -1, 1'b0);

    // Slow address ack plus stray bvalid during read data
    req_on(1'b0, 1'b0, 64'h5000);
    serve(1'b0, 1'b0, 64'h5000, 64'hE000, 5, -1, 1'b1);

    // Reset on beat 2 of a read, then a fresh grant
    req_on(1'b0, 1'b0, 64'h6000);
    serve(1'b0, 1'b0, 64'h6000, 64'hF000, 0, 2, 1'b0);
    req_on(1'b0, 1'b0, 64'h7000);
    serve(1'b0, 1'b0, 64'h7000, 64'h9000, 0, -1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
